// File: rtl/pong_game_ctrl.sv
// Game sequencer for the VGA pong datapath: attract/serve/play/miss/over flow,
// ball reload pulses, BCD score and remaining lives, all paced by frame_tick.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int BALL_X0      = 312,
  parameter int BALL_Y0      = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       paddle_hit,
  input  logic       ball_lost,
  output logic       motion_en,
  output logic       ball_load,
  output logic [9:0] ball_x0,
  output logic [8:0] ball_y0,
  output logic       ball_dir_x0,
  output logic [7:0] score_bcd,
  output logic [3:0] lives,
  output logic [2:0] state,
  output logic       game_over,
  output logic       serve_blink
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] SERVE_INIT = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_INIT  = 8'(MISS_FRAMES);

  state_t     st;
  logic [7:0] timer;
  logic       startQ;
  logic       startRise;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcdIncSat(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign startRise = start & ~startQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      motion_en   <= 1'b0;
      ball_load   <= 1'b0;
      ball_dir_x0 <= 1'b0;
      score_bcd   <= 8'h00;
      lives       <= LIVES_INIT;
      timer       <= 8'd0;
      // Start as if the button were already down, so holding it through reset is not a press.
      startQ      <= 1'b1;
    end else begin
      startQ    <= start;
      ball_load <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (startRise) begin
            score_bcd   <= 8'h00;
            lives       <= LIVES_INIT;
            timer       <= SERVE_INIT;
            ball_load   <= 1'b1;
            ball_dir_x0 <= ~ball_dir_x0;
            motion_en   <= 1'b0;
            st          <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (timer <= 8'd1) begin
              motion_en <= 1'b1;
              st        <= PLAY;
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        PLAY: begin
          if (ball_lost) begin
            lives     <= (lives != 4'd0) ? lives - 4'd1 : 4'd0;
            timer     <= MISS_INIT;
            motion_en <= 1'b0;
            st        <= MISS;
          end else if (paddle_hit) begin
            score_bcd <= bcdIncSat(score_bcd);
          end
        end
        MISS: begin
          if (frame_tick) begin
            if (timer <= 8'd1) begin
              if (lives == 4'd0) begin
                st <= OVER;
              end else begin
                ball_load   <= 1'b1;
                ball_dir_x0 <= ~ball_dir_x0;
                timer       <= SERVE_INIT;
                st          <= SERVE;
              end
            end else begin
              timer <= timer - 8'd1;
            end
          end
        end
        default: begin
          motion_en <= 1'b0;
          st        <= IDLE;
        end
      endcase
    end
  end

  assign state       = st;
  assign game_over   = (st == OVER);
  assign serve_blink = (st == SERVE) & timer[3];
  assign ball_x0     = 10'(BALL_X0);
  assign ball_y0     = 9'(BALL_Y0);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: vector table, hand sequences and randomized play
// against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int LIVES = 2;
  localparam int SF    = 4;
  localparam int MF    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frameTick, start, paddleHit, ballLost;
  logic       motion_en, ball_load, ball_dir_x0, game_over, serve_blink;
  logic [9:0] ball_x0;
  logic [8:0] ball_y0;
  logic [7:0] score_bcd;
  logic [3:0] lives;
  logic [2:0] state;

  logic       motion2, load2, dir2, over2, blink2;
  logic [9:0] x2;
  logic [8:0] y2;
  logic [7:0] score2;
  logic [3:0] lives2;
  logic [2:0] state2;

  always #5 clk = ~clk;

  pong_game_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(SF), .MISS_FRAMES(MF),
                   .BALL_X0(312), .BALL_Y0(100)) dut (
    .clk(clk), .reset(reset), .frame_tick(frameTick), .start(start),
    .paddle_hit(paddleHit), .ball_lost(ballLost), .motion_en(motion_en),
    .ball_load(ball_load), .ball_x0(ball_x0), .ball_y0(ball_y0),
    .ball_dir_x0(ball_dir_x0), .score_bcd(score_bcd), .lives(lives),
    .state(state), .game_over(game_over), .serve_blink(serve_blink));

  // Longer serve so that timer bit 3 is actually exercised for serve_blink.
  pong_game_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(12), .MISS_FRAMES(MF),
                   .BALL_X0(312), .BALL_Y0(100)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frameTick), .start(start),
    .paddle_hit(paddleHit), .ball_lost(ballLost), .motion_en(motion2),
    .ball_load(load2), .ball_x0(x2), .ball_y0(y2),
    .ball_dir_x0(dir2), .score_bcd(score2), .lives(lives2),
    .state(state2), .game_over(over2), .serve_blink(blink2));

  logic [19:0] dutVec;
  assign dutVec = {state, motion_en, ball_load, ball_dir_x0, score_bcd, lives, game_over, serve_blink};

  int tests = 0;
  int fails = 0;
  int cycleNo = 0;

  // Behavioural model: mode 0 idle,1 serve,2 play,3 miss,4 over; score kept as a decimal integer.
  int mMode, mScore, mLives, mTimer;
  bit mDir, mLoad, mPrev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] toBcd(input int s);
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  task automatic modelReset();
    mMode = 0; mScore = 0; mLives = LIVES; mTimer = 0;
    mDir = 1'b0; mLoad = 1'b0; mPrev = 1'b1;
  endtask

  task automatic modelStep(input bit t, input bit s, input bit h, input bit l);
    bit rise;
    rise  = s && !mPrev;
    mPrev = s;
    mLoad = 1'b0;
    if (mMode == 0 || mMode == 4) begin
      if (rise) begin
        mScore = 0; mLives = LIVES; mTimer = SF;
        mLoad = 1'b1; mDir = !mDir; mMode = 1;
      end
    end else if (mMode == 1) begin
      if (t) begin
        if (mTimer == 1) mMode = 2;
        else mTimer = mTimer - 1;
      end
    end else if (mMode == 2) begin
      if (l) begin
        mLives = (mLives > 0) ? mLives - 1 : 0;
        mTimer = MF; mMode = 3;
      end else if (h && mScore < 99) begin
        mScore = mScore + 1;
      end
    end else begin
      if (t) begin
        if (mTimer > 1) mTimer = mTimer - 1;
        else if (mLives == 0) mMode = 4;
        else begin
          mLoad = 1'b1; mDir = !mDir; mTimer = SF; mMode = 1;
        end
      end
    end
  endtask

  function automatic logic [19:0] modelVec();
    logic blink;
    blink = (mMode == 1) && ((mTimer / 8) % 2 == 1);
    return {3'(mMode), mMode == 2, mLoad, mDir, toBcd(mScore), 4'(mLives), mMode == 4, blink};
  endfunction

  task automatic cyc(input logic t, input logic s, input logic h, input logic l);
    frameTick = t; start = s; paddleHit = h; ballLost = l;
    @(posedge clk);
    #1;
    cycleNo++;
    modelStep(t, s, h, l);
    chk($sformatf("model@%0d", cycleNo), {12'd0, dutVec}, {12'd0, modelVec()});
  endtask

  typedef struct {
    logic t, s, h, l;
    logic [2:0] st;
    logic mot, ld, dir;
    logic [7:0] sc;
    logic [3:0] lv;
    logic ov, bl2;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic t, s, h, l, input logic [2:0] st, input logic mot, ld, dir,
                     input logic [7:0] sc, input logic [3:0] lv, input logic ov, bl2);
    vec_t v;
    v.t = t; v.s = s; v.h = h; v.l = l; v.st = st; v.mot = mot; v.ld = ld; v.dir = dir;
    v.sc = sc; v.lv = lv; v.ov = ov; v.bl2 = bl2;
    tbl.push_back(v);
  endtask

  logic loadSeen;
  logic sLvl;

  initial begin
    // tick start hit lost | state mot load dir score lives over blink2
    row(0,1,0,0, 1'd0 ? 3'd0 : 3'd0,0,0,0, 8'h00,4'd2,0,0);
    row(0,0,0,0, 3'd0,0,0,0, 8'h00,4'd2,0,0);
    row(0,1,0,0, 3'd1,0,1,1, 8'h00,4'd2,0,1);
    row(0,1,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,1);
    row(1,0,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,1);
    row(1,0,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,1);
    row(1,0,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,1);
    row(0,0,1,0, 3'd1,0,0,1, 8'h00,4'd2,0,1);
    row(1,0,0,0, 3'd2,1,0,1, 8'h00,4'd2,0,1);
    row(0,0,1,0, 3'd2,1,0,1, 8'h01,4'd2,0,1);
    row(0,0,1,1, 3'd3,0,0,1, 8'h01,4'd1,0,1);
    row(1,0,0,0, 3'd3,0,0,1, 8'h01,4'd1,0,0);
    row(1,0,0,0, 3'd1,0,1,0, 8'h01,4'd1,0,0);
    row(0,0,0,0, 3'd1,0,0,0, 8'h01,4'd1,0,0);
    row(1,0,0,0, 3'd1,0,0,0, 8'h01,4'd1,0,0);
    row(1,0,0,0, 3'd1,0,0,0, 8'h01,4'd1,0,0);
    row(1,0,0,0, 3'd1,0,0,0, 8'h01,4'd1,0,0);
    row(1,0,0,0, 3'd2,1,0,0, 8'h01,4'd1,0,0);
    row(0,0,0,1, 3'd3,0,0,0, 8'h01,4'd0,0,0);
    row(1,0,0,0, 3'd3,0,0,0, 8'h01,4'd0,0,0);
    row(1,0,0,0, 3'd4,0,0,0, 8'h01,4'd0,1,0);
    row(1,1,0,0, 3'd1,0,1,1, 8'h00,4'd2,0,0);
    row(0,0,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,0);
    row(0,1,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,0);
    row(0,0,0,0, 3'd1,0,0,1, 8'h00,4'd2,0,0);

    reset = 1'b1; start = 1'b1; frameTick = 1'b0; paddleHit = 1'b0; ballLost = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {12'd0, dutVec}, {12'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 1'b0});
    chk("ball_pos", {13'd0, ball_x0, ball_y0}, {13'd0, 10'd312, 9'd100});
    reset = 1'b0;
    modelReset();

    foreach (tbl[i]) begin
      cyc(tbl[i].t, tbl[i].s, tbl[i].h, tbl[i].l);
      chk($sformatf("row%0d", i),
          {12'd0, state, motion_en, ball_load, ball_dir_x0, score_bcd, lives, game_over, blink2},
          {12'd0, tbl[i].st, tbl[i].mot, tbl[i].ld, tbl[i].dir, tbl[i].sc, tbl[i].lv, tbl[i].ov, tbl[i].bl2});
    end

    // Serve with real frame spacing, then play.
    for (int i = 0; i < 4; i++) begin
      repeat (19) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    chk("play_entry", {state, motion_en}, {3'd2, 1'b1});
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("start_in_play", {state, motion_en, ball_load}, {3'd2, 1'b1, 1'b0});
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("score12", score_bcd, 8'h12);
    for (int i = 0; i < 86; i++) cyc(0, 0, 1, 0);
    chk("score98", score_bcd, 8'h98);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("score99_sat", score_bcd, 8'h99);

    // Asynchronous reset in the middle of a play frame.
    #4;
    reset = 1'b1;
    #1;
    chk("rst_async", {state, motion_en, ball_load, score_bcd, lives},
        {3'd0, 1'b0, 1'b0, 8'h00, 4'd2});
    loadSeen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ball_load) loadSeen = 1'b1;
    end
    reset = 1'b0;
    modelReset();
    repeat (3) begin
      cyc(0, 0, 0, 0);
      if (ball_load) loadSeen = 1'b1;
    end
    chk("rst_noload", {31'd0, loadSeen}, 32'd0);

    // Randomized play against the model.
    sLvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) sLvl = ~sLvl;
      cyc((i % 20) == 19, sLvl, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
